hex7_capture: RTL and testbench

Inverse of the board's hex-to-seven-segment encoder. Accepts a stream of active-low 7-bit segment patterns over a valid/ready handshake, decodes each back to a 4-bit hex digit, and assembles NUM_DIGITS digits into one word with per-digit error flags. Used by the self-check and readback path that confirms what the Lights Out display drivers actually present.

---
 rtl/hex7_pkg.sv | 31 +++
 rtl/hex7_inv.sv | 44 ++++
 rtl/hex7_capture.sv | 81 ++++++++
 tb/tb_hex7_capture.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex7_pkg.sv
// Shared segment codes, FSM state and decode-result types for the hex7 readback path.
package hex7_pkg;

  // Active-low patterns, bit0 = segment a ... bit6 = segment g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [3:0] digit;
    logic       illegal;
    logic       blank;
  } dec_t;

endpackage

// File: rtl/hex7_inv.sv
// Combinational inverse of the hex-to-seven-segment encoder (exact match only).
// HEX7_BLANK_EN makes the all-off pattern a legal blank digit.
module hex7_inv
  import hex7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       illegal,
  output logic       blank
);

  always_comb begin
    digit   = 4'h0;
    illegal = 1'b0;
    blank   = 1'b0;
    case (seg)
      SEG_0: digit = 4'h0;
      SEG_1: digit = 4'h1;
      SEG_2: digit = 4'h2;
      SEG_3: digit = 4'h3;
      SEG_4: digit = 4'h4;
      SEG_5: digit = 4'h5;
      SEG_6: digit = 4'h6;
      SEG_7: digit = 4'h7;
      SEG_8: digit = 4'h8;
      SEG_9: digit = 4'h9;
      SEG_A: digit = 4'hA;
      SEG_B: digit = 4'hB;
      SEG_C: digit = 4'hC;
      SEG_D: digit = 4'hD;
      SEG_E: digit = 4'hE;
      SEG_F: digit = 4'hF;
      default: begin
`ifdef HEX7_BLANK_EN
        if (seg == SEG_BLANK) blank = 1'b1;
        else                  illegal = 1'b1;
`else
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/hex7_capture.sv
// Assembles NUM_DIGITS decoded seven-segment beats into one word with err/blank masks.
// HEX7_BLANK_EN (in hex7_inv) enables blank digits; without it the blank mask stays 0.
module hex7_capture
  import hex7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              in_seg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic [NUM_DIGITS-1:0]   out_err_mask,
  output logic                    out_err,
  output logic [NUM_DIGITS-1:0]   out_blank_mask
);

  localparam int CW = $clog2(NUM_DIGITS + 1);

  state_t                  state;
  logic [CW-1:0]           cnt;
  dec_t                    dec;
  logic                    beat;
  logic [4*NUM_DIGITS-1:0] val_nx;
  logic [NUM_DIGITS-1:0]   err_nx;
  logic [NUM_DIGITS-1:0]   blank_nx;

  hex7_inv u_inv (
    .seg     (in_seg),
    .digit   (dec.digit),
    .illegal (dec.illegal),
    .blank   (dec.blank)
  );

  // Handshake outputs come from state alone, never from in_valid/out_ready.
  assign in_ready  = (state == COLLECT);
  assign out_valid = (state == HOLD);
  assign beat      = in_valid & in_ready;
  assign out_err   = |out_err_mask;

  // New digit enters at the low end, so the first digit ends up most significant.
  if (NUM_DIGITS == 1) begin : g_one
    assign val_nx   = dec.digit;
    assign err_nx   = dec.illegal;
    assign blank_nx = dec.blank;
  end else begin : g_many
    assign val_nx   = {out_value[4*NUM_DIGITS-5:0], dec.digit};
    assign err_nx   = {out_err_mask[NUM_DIGITS-2:0], dec.illegal};
    assign blank_nx = {out_blank_mask[NUM_DIGITS-2:0], dec.blank};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= COLLECT;
      cnt            <= '0;
      out_value      <= '0;
      out_err_mask   <= '0;
      out_blank_mask <= '0;
    end else begin
      case (state)
        COLLECT: if (beat) begin
          out_value      <= val_nx;
          out_err_mask   <= err_nx;
          out_blank_mask <= blank_nx;
          if (cnt == CW'(NUM_DIGITS - 1)) begin
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: if (out_ready) state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_hex7_capture.sv
// Directed and randomized checks of hex7_capture (4-digit and 1-digit instances).
module tb_hex7_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [6:0]  in_seg;
  logic [15:0] out_value;
  logic [3:0]  out_err_mask, out_blank_mask;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_err1;
  logic [6:0]  in_seg1;
  logic [3:0]  out_value1;
  logic [0:0]  out_err_mask1, out_blank_mask1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex7_capture #(.NUM_DIGITS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_seg(in_seg),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_err_mask(out_err_mask), .out_err(out_err), .out_blank_mask(out_blank_mask)
  );

  hex7_capture #(.NUM_DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1), .in_seg(in_seg1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_value(out_value1),
    .out_err_mask(out_err_mask1), .out_err(out_err1), .out_blank_mask(out_blank_mask1)
  );

  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Returns {nibble, err, blank} for one pattern.
  function automatic logic [5:0] ref_dec(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (codes[i] == s) return {4'(i), 1'b0, 1'b0};
`ifdef HEX7_BLANK_EN
    if (s == 7'h7F) return {4'h0, 1'b0, 1'b1};
`endif
    return {4'h0, 1'b1, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) begin
      failures++;
      $display("FAIL in_ready_timeout: observed 0 expected 1");
    end
  endtask

  // Drives four beats back-to-back; returns just after the last accepting edge.
  task automatic send_word(input logic [27:0] w);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_seg   = w[27-7*i -: 7];
      wait_ready();
      tick();
    end
    in_valid = 1'b0;
  endtask

  logic [23:0] exp_q [$];
  int          got_words;

  task automatic producer();
    for (int w = 0; w < 1000; w++) begin
      logic [23:0] e = '0;
      for (int d = 0; d < 4; d++) begin
        logic [6:0] p;
        logic [5:0] r;
        int k = int'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) begin
          p = codes[k];
          r = {4'(k), 2'b00};
        end else begin
          p = 7'($urandom);
          r = ref_dec(p);
        end
        e[23:8] = {e[19:8], r[5:2]};
        e[7:4]  = {e[6:4], r[1]};
        e[3:0]  = {e[2:0], r[0]};
        repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_seg   = p;
        wait_ready();
        tick();
        in_valid = 1'b0;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic consumer();
    int cyc = 0;
    got_words = 0;
    while (got_words < 1000 && cyc < 60000) begin
      logic        ov = out_valid;
      logic [15:0] oval = out_value;
      logic        ordy = 1'($urandom_range(0, 2) != 0);
      out_ready = ordy;
      tick();
      cyc++;
      if (ov && ordy) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_dup: observed extra word %h expected none", oval);
        end else begin
          logic [23:0] e = exp_q.pop_front();
          chk("rand_word", {oval, out_err_mask, out_blank_mask}, e);
        end
        got_words++;
      end else if (ov) begin
        chk("rand_hold", {out_valid, out_value}, {1'b1, oval});
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_err, exp_blank;
    logic [5:0] e1;
    int legal;
    reset = 1'b1; in_valid = 1'b0; in_seg = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_seg1 = '0; out_ready1 = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_value", out_value, 16'h0);
    chk("rst_err_mask", out_err_mask, 4'h0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_blank", out_blank_mask, 4'h0);

    // Back-to-back word, consumer ready
    send_word({7'h24, 7'h30, 7'h12, 7'h0E});
    chk("w1_valid", out_valid, 1'b1);
    chk("w1_value", out_value, 16'h235F);
    chk("w1_err", out_err, 1'b0);
    tick();
    chk("w1_consumed", {out_valid, in_ready}, 2'b01);

    // Illegal and blank patterns
    out_ready = 1'b0;
    send_word({7'h40, 7'h7F, 7'h79, 7'h55});
`ifdef HEX7_BLANK_EN
    exp_err = 4'b0001; exp_blank = 4'b0100;
`else
    exp_err = 4'b0101; exp_blank = 4'b0000;
`endif
    chk("w2_value", out_value, 16'h0010);
    chk("w2_err_mask", out_err_mask, exp_err);
    chk("w2_blank", out_blank_mask, exp_blank);
    chk("w2_err", out_err, 1'b1);
    out_ready = 1'b1;
    tick();

    // Stall in HOLD with in_valid asserted
    out_ready = 1'b0;
    send_word({7'h40, 7'h79, 7'h24, 7'h30});
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_seg   = codes[15 - i];
      tick();
      chk("hold_stall", {in_ready, out_valid, out_value}, {2'b01, 16'h0123});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("hold_release", {in_ready, out_valid, out_value}, {2'b10, 16'h0123});
    send_word({7'h78, 7'h00, 7'h18, 7'h08});
    chk("after_hold", {out_valid, out_value, out_err_mask}, {1'b1, 16'h789A, 4'h0});
    tick();

    // Reset mid-frame
    in_valid = 1'b1; in_seg = 7'h19; tick();
    in_seg = 7'h12; tick();
    in_valid = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst", {out_valid, in_ready, out_value, out_err_mask}, {2'b01, 16'h0, 4'h0});
    send_word({7'h08, 7'h03, 7'h46, 7'h21});
    chk("post_rst_word", {out_valid, out_value, out_err_mask}, {1'b1, 16'hABCD, 4'h0});
    tick();

    // Full pattern sweep on the single-digit instance
    legal = 0;
    for (int p = 0; p < 128; p++) begin
      in_valid1 = 1'b1;
      in_seg1   = 7'(p);
      tick();
      in_valid1 = 1'b0;
      e1 = ref_dec(7'(p));
      chk("sweep", {out_valid1, out_value1, out_err_mask1, out_blank_mask1}, {1'b1, e1});
      if (out_valid1 && !out_err_mask1[0]) legal++;
      tick();
    end
`ifdef HEX7_BLANK_EN
    chk("sweep_legal", legal, 17);
`else
    chk("sweep_legal", legal, 16);
`endif

    // Randomized stalls, scoreboarded
    fork
      producer();
      consumer();
    join
    chk("rand_words", got_words, 1000);
    chk("rand_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
